// File: rtl/rtc_bcd_counter.sv
// HH:MM:SS real-time counter with internal one-second tick, 12/24-hour display
// and hour/minute set buttons with auto-repeat. Single clock, synchronous reset.
module rtc_bcd_counter #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned REPEAT_DLY  = 25_000_000,
  parameter int unsigned REPEAT_RATE = 10_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       button_hr_i,
  input  logic       button_min_i,
  input  logic       mode12_i,
  output logic [1:0] hr1_o,
  output logic [3:0] hr2_o,
  output logic [2:0] min1_o,
  output logic [3:0] min2_o,
  output logic [2:0] sec1_o,
  output logic [3:0] sec2_o,
  output logic       pm_o,
  output logic       sec_tick_o
);

  localparam int unsigned TW   = $clog2(TICK_DIV);
  localparam int unsigned MAXC = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;

  logic [1:0] hr_sync_q, hr_sync_d, min_sync_q, min_sync_d;
  logic       hr_held, min_held, set_mode;

  rpt_state_e hr_st_q, hr_st_d, min_st_q, min_st_d;
  logic [CW-1:0] hr_cnt_q, hr_cnt_d, min_cnt_q, min_cnt_d;
  logic       hr_inc, min_inc;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic       tick, tick_q;
  logic [4:0] hours_q, hours_d;
  logic [2:0] min1_q, min1_d, sec1_q, sec1_d;
  logic [3:0] min2_q, min2_d, sec2_q, sec2_d;

  logic [4:0] hr_disp;
  logic [1:0] hr1_q, hr1_d;
  logic [3:0] hr2_q, hr2_d;
  logic       pm_q, pm_d, sec_tick_q;
  logic [2:0] dmin1_q, dsec1_q;
  logic [3:0] dmin2_q, dsec2_q;

  always_comb begin
    hr_sync_d  = {hr_sync_q[0], button_hr_i};
    min_sync_d = {min_sync_q[0], button_min_i};
    hr_held    = hr_sync_q[1];
    // minute button is masked while the hour button is held
    min_held   = min_sync_q[1] & ~hr_sync_q[1];
    set_mode   = hr_sync_q[1] | min_sync_q[1];
  end

  // Idle state doubles as the rising-edge detector: first held cycle increments.
  always_comb begin
    hr_st_d  = hr_st_q;
    hr_cnt_d = '0;
    hr_inc   = 1'b0;
    if (!hr_held) begin
      hr_st_d = RPT_IDLE;
    end else begin
      case (hr_st_q)
        RPT_IDLE: begin
          hr_inc  = 1'b1;
          hr_st_d = RPT_DELAY;
        end
        RPT_DELAY: begin
          if (hr_cnt_q == DLY_LAST) begin
            hr_inc  = 1'b1;
            hr_st_d = RPT_REPEAT;
          end else begin
            hr_cnt_d = hr_cnt_q + CW'(1);
          end
        end
        RPT_REPEAT: begin
          if (hr_cnt_q == RATE_LAST) hr_inc = 1'b1;
          else hr_cnt_d = hr_cnt_q + CW'(1);
        end
        default: hr_st_d = RPT_IDLE;
      endcase
    end
  end

  always_comb begin
    min_st_d  = min_st_q;
    min_cnt_d = '0;
    min_inc   = 1'b0;
    if (!min_held) begin
      min_st_d = RPT_IDLE;
    end else begin
      case (min_st_q)
        RPT_IDLE: begin
          min_inc  = 1'b1;
          min_st_d = RPT_DELAY;
        end
        RPT_DELAY: begin
          if (min_cnt_q == DLY_LAST) begin
            min_inc  = 1'b1;
            min_st_d = RPT_REPEAT;
          end else begin
            min_cnt_d = min_cnt_q + CW'(1);
          end
        end
        RPT_REPEAT: begin
          if (min_cnt_q == RATE_LAST) min_inc = 1'b1;
          else min_cnt_d = min_cnt_q + CW'(1);
        end
        default: min_st_d = RPT_IDLE;
      endcase
    end
  end

  always_comb begin
    tcnt_d  = tcnt_q;
    hours_d = hours_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    sec1_d  = sec1_q;
    sec2_d  = sec2_q;
    tick    = 1'b0;
    if (set_mode) begin
      tcnt_d = '0;
      sec1_d = '0;
      sec2_d = '0;
      if (hr_inc) begin
        hours_d = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
      end else if (min_inc) begin
        if (min2_q == 4'd9) begin
          min2_d = '0;
          min1_d = (min1_q == 3'd5) ? '0 : min1_q + 3'd1;
        end else begin
          min2_d = min2_q + 4'd1;
        end
      end
    end else if (tcnt_q == TICK_LAST) begin
      tick   = 1'b1;
      tcnt_d = '0;
      if (sec2_q != 4'd9) begin
        sec2_d = sec2_q + 4'd1;
      end else begin
        sec2_d = '0;
        if (sec1_q != 3'd5) begin
          sec1_d = sec1_q + 3'd1;
        end else begin
          sec1_d = '0;
          if (min2_q != 4'd9) begin
            min2_d = min2_q + 4'd1;
          end else begin
            min2_d = '0;
            if (min1_q != 3'd5) begin
              min1_d = min1_q + 3'd1;
            end else begin
              min1_d  = '0;
              hours_d = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
            end
          end
        end
      end
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_comb begin
    hr_disp = hours_q;
    pm_d    = 1'b0;
    if (mode12_i) begin
      pm_d = (hours_q >= 5'd12);
      if (hours_q == 5'd0)       hr_disp = 5'd12;
      else if (hours_q > 5'd12)  hr_disp = hours_q - 5'd12;
    end
    if (hr_disp >= 5'd20) begin
      hr1_d = 2'd2;
      hr2_d = 4'(hr_disp - 5'd20);
    end else if (hr_disp >= 5'd10) begin
      hr1_d = 2'd1;
      hr2_d = 4'(hr_disp - 5'd10);
    end else begin
      hr1_d = 2'd0;
      hr2_d = 4'(hr_disp);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hr_sync_q  <= '0;
      min_sync_q <= '0;
      hr_st_q    <= RPT_IDLE;
      min_st_q   <= RPT_IDLE;
      hr_cnt_q   <= '0;
      min_cnt_q  <= '0;
      tcnt_q     <= '0;
      tick_q     <= 1'b0;
      hours_q    <= '0;
      min1_q     <= '0;
      min2_q     <= '0;
      sec1_q     <= '0;
      sec2_q     <= '0;
      hr1_q      <= '0;
      hr2_q      <= '0;
      dmin1_q    <= '0;
      dmin2_q    <= '0;
      dsec1_q    <= '0;
      dsec2_q    <= '0;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      hr_sync_q  <= hr_sync_d;
      min_sync_q <= min_sync_d;
      hr_st_q    <= hr_st_d;
      min_st_q   <= min_st_d;
      hr_cnt_q   <= hr_cnt_d;
      min_cnt_q  <= min_cnt_d;
      tcnt_q     <= tcnt_d;
      tick_q     <= tick;
      hours_q    <= hours_d;
      min1_q     <= min1_d;
      min2_q     <= min2_d;
      sec1_q     <= sec1_d;
      sec2_q     <= sec2_d;
      hr1_q      <= hr1_d;
      hr2_q      <= hr2_d;
      dmin1_q    <= min1_q;
      dmin2_q    <= min2_q;
      dsec1_q    <= sec1_q;
      dsec2_q    <= sec2_q;
      pm_q       <= pm_d;
      sec_tick_q <= tick_q;
    end
  end

  assign hr1_o      = hr1_q;
  assign hr2_o      = hr2_q;
  assign min1_o     = dmin1_q;
  assign min2_o     = dmin2_q;
  assign sec1_o     = dsec1_q;
  assign sec2_o     = dsec2_q;
  assign pm_o       = pm_q;
  assign sec_tick_o = sec_tick_q;

endmodule
